// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART <-> ALU frame controller.
package uart_alu_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int NB_OP_DEF   = 6;
  localparam int TIMEOUT_DEF = 1000000;

  typedef enum logic [2:0] {
    S_A       = 3'd0,
    S_B       = 3'd1,
    S_OP      = 3'd2,
    S_EXEC    = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

  // Watchdog counter width; never below one bit.
  function automatic int wd_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of UART/ALU-side signals seen by the frame controller.
interface uart_alu_ctrl_if #(
  parameter int DBIT  = uart_alu_pkg::DBIT_DEF,
  parameter int NB_OP = uart_alu_pkg::NB_OP_DEF
);

  logic [DBIT-1:0]  i_rx_data;
  logic             i_rx_done_tick;
  logic             i_tx_done_tick;
  logic [DBIT-1:0]  i_alu_result;
  logic [DBIT-1:0]  o_alu_a;
  logic [DBIT-1:0]  o_alu_b;
  logic [NB_OP-1:0] o_alu_op;
  logic [DBIT-1:0]  o_tx_data;
  logic             o_tx_start;
  logic             o_busy;
  logic             o_timeout_tick;
  logic             o_overrun_tick;

  // Controller side.
  modport master (
    input  i_rx_data, i_rx_done_tick, i_tx_done_tick, i_alu_result,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
           o_busy, o_timeout_tick, o_overrun_tick
  );

  // UART / ALU side.
  modport slave (
    output i_rx_data, i_rx_done_tick, i_tx_done_tick, i_alu_result,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start,
           o_busy, o_timeout_tick, o_overrun_tick
  );

endinterface

// File: rtl/watchdog_timer.sv
// Idle-cycle counter: flags expiry on the TIMEOUT-th enabled cycle.
module watchdog_timer #(
  parameter int TIMEOUT = uart_alu_pkg::TIMEOUT_DEF,
  parameter int CNT_W   = uart_alu_pkg::wd_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; a clear restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of block ordering.
      count <= count + CNT_W'(1);
    end
  end

  // Expiry is combinational so the FSM can act on the same edge.
  always_comb begin
    expire = enable && (count == LIMIT);
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame controller: collects A, B, opcode bytes, feeds the ALU and
// launches the result on the UART transmitter, with a watchdog.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int NB_OP   = NB_OP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           i_clock,
  input  logic           i_reset,
  uart_alu_ctrl_if.master bus
);

  state_t          state;
  state_t          state_next;
  logic            load_a;
  logic            load_b;
  logic            load_op;
  logic            abort;
  logic            overrun;
  logic            wd_enable;
  logic            wd_expire;
  logic [DBIT-1:0] rx_byte;

  assign rx_byte = bus.i_rx_data;

  // Watchdog runs only while waiting on the far end; any state change
  // restarts it.
  assign wd_enable = (state == S_B) || (state == S_OP) || (state == S_WAIT_TX);

  watchdog_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (i_clock),
    .rst_n  (i_reset),
    .clear  (state_next != state),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_A;
    else          state <= state_next;
  end

  // Next-state and load decisions; an advancing event beats watchdog expiry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    abort      = 1'b0;
    overrun    = 1'b0;
    unique case (state)
      S_A: begin
        if (bus.i_rx_done_tick) begin
          load_a     = 1'b1;
          state_next = S_B;
        end
      end
      S_B: begin
        if (bus.i_rx_done_tick) begin
          load_b     = 1'b1;
          state_next = S_OP;
        end else if (wd_expire) begin
          abort      = 1'b1;
          state_next = S_A;
        end
      end
      S_OP: begin
        if (bus.i_rx_done_tick) begin
          load_op    = 1'b1;
          state_next = S_EXEC;
        end else if (wd_expire) begin
          abort      = 1'b1;
          state_next = S_A;
        end
      end
      S_EXEC: begin
        overrun    = bus.i_rx_done_tick;
        state_next = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        overrun = bus.i_rx_done_tick;
        if (bus.i_tx_done_tick) begin
          state_next = S_A;
        end else if (wd_expire) begin
          abort      = 1'b1;
          state_next = S_A;
        end
      end
      default: state_next = S_A;
    endcase
  end

  // Registered outputs: operands, transmit byte/start and status pulses.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: every output register is reset so the link side sees a
      // defined, idle interface the moment reset asserts.
      bus.o_alu_a        <= '0;
      bus.o_alu_b        <= '0;
      bus.o_alu_op       <= '0;
      bus.o_tx_data      <= '0;
      bus.o_tx_start     <= 1'b0;
      bus.o_busy         <= 1'b0;
      bus.o_timeout_tick <= 1'b0;
      bus.o_overrun_tick <= 1'b0;
    end else begin
      if (load_a)  bus.o_alu_a  <= rx_byte;
      if (load_b)  bus.o_alu_b  <= rx_byte;
      if (load_op) bus.o_alu_op <= rx_byte[NB_OP-1:0];
      if (state == S_EXEC) bus.o_tx_data <= bus.i_alu_result;
      bus.o_tx_start     <= (state == S_EXEC);
      bus.o_busy         <= (state_next != S_A);
      bus.o_timeout_tick <= abort;
      bus.o_overrun_tick <= overrun;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl with a frame-level reference model.
module tb_uart_alu_ctrl;

  localparam int DBIT    = 8;
  localparam int NB_OP   = 6;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  uart_alu_ctrl_if #(.DBIT(DBIT), .NB_OP(NB_OP)) bus ();

  uart_alu_ctrl #(
    .DBIT    (DBIT),
    .NB_OP   (NB_OP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: 0x20 add, 0x22 subtract, anything else xor.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign bus.i_alu_result = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int         nbytes       = 0;   // bytes of the current frame collected
  bit         exec_pending = 0;   // opcode taken, result not launched yet
  bit         in_tx        = 0;   // waiting for the transmitter
  int         idle         = 0;   // cycles spent waiting without an event
  logic [7:0] m_a = '0, m_b = '0, m_tx_data = '0;
  logic [5:0] m_op = '0;
  logic       m_tx_start = 0, m_busy = 0, m_timeout = 0, m_overrun = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nbytes = 0; exec_pending = 0; in_tx = 0; idle = 0;
      m_a = '0; m_b = '0; m_op = '0; m_tx_data = '0;
      m_tx_start = 0; m_busy = 0; m_timeout = 0; m_overrun = 0;
    end else begin
      m_tx_start = 0; m_timeout = 0; m_overrun = 0;
      if (exec_pending) begin
        m_overrun    = bus.i_rx_done_tick;
        m_tx_data    = alu_ref(m_a, m_b, m_op);
        m_tx_start   = 1;
        exec_pending = 0;
        in_tx        = 1;
        idle         = 0;
      end else if (in_tx) begin
        m_overrun = bus.i_rx_done_tick;
        if (bus.i_tx_done_tick) begin
          in_tx = 0; idle = 0;
        end else if (idle == TIMEOUT - 1) begin
          in_tx = 0; idle = 0; m_timeout = 1;
        end else idle++;
      end else if (bus.i_rx_done_tick) begin
        if (nbytes == 0)      begin m_a = bus.i_rx_data; nbytes = 1; end
        else if (nbytes == 1) begin m_b = bus.i_rx_data; nbytes = 2; end
        else begin
          m_op = bus.i_rx_data[5:0]; nbytes = 0; exec_pending = 1;
        end
        idle = 0;
      end else if (nbytes > 0) begin
        if (idle == TIMEOUT - 1) begin
          nbytes = 0; idle = 0; m_timeout = 1;
        end else idle++;
      end
      m_busy = (nbytes > 0) || exec_pending || in_tx;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("cmp_alu_a",   bus.o_alu_a,        m_a);
      check("cmp_alu_b",   bus.o_alu_b,        m_b);
      check("cmp_alu_op",  bus.o_alu_op,       m_op);
      check("cmp_tx_data", bus.o_tx_data,      m_tx_data);
      check("cmp_tx_start", bus.o_tx_start,    m_tx_start);
      check("cmp_busy",    bus.o_busy,         m_busy);
      check("cmp_timeout", bus.o_timeout_tick, m_timeout);
      check("cmp_overrun", bus.o_overrun_tick, m_overrun);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data      = b;
    bus.i_rx_done_tick = 1'b1;
    @(negedge clk);
    bus.i_rx_done_tick = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.i_tx_done_tick = 1'b1;
    @(negedge clk);
    bus.i_tx_done_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_alu_a"},   bus.o_alu_a,        0);
    check({tag, "_alu_b"},   bus.o_alu_b,        0);
    check({tag, "_alu_op"},  bus.o_alu_op,       0);
    check({tag, "_tx_data"}, bus.o_tx_data,      0);
    check({tag, "_tx_start"}, bus.o_tx_start,    0);
    check({tag, "_busy"},    bus.o_busy,         0);
    check({tag, "_timeout"}, bus.o_timeout_tick, 0);
    check({tag, "_overrun"}, bus.o_overrun_tick, 0);
  endtask

  initial begin
    int n;
    rst_n              = 1'b0;
    bus.i_rx_data      = '0;
    bus.i_rx_done_tick = 1'b0;
    bus.i_tx_done_tick = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD frame: result launched one cycle after the opcode edge.
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    check("add_alu_a", bus.o_alu_a, 8'h05);
    check("add_alu_b", bus.o_alu_b, 8'h03);
    check("add_alu_op", bus.o_alu_op, 6'h20);
    check("add_start_early", bus.o_tx_start, 0);
    @(negedge clk);
    check("add_start", bus.o_tx_start, 1);
    check("add_tx_data", bus.o_tx_data, 8'h08);
    @(negedge clk);
    check("add_start_once", bus.o_tx_start, 0);
    check("add_busy_wait", bus.o_busy, 1);
    pulse_tx_done();
    check("add_idle", bus.o_busy, 0);

    // Opcode upper bits are discarded: 0xE2 -> 0x22 (subtract).
    send_byte(8'h09);
    send_byte(8'h04);
    send_byte(8'hE2);
    check("op_mask", bus.o_alu_op, 6'h22);
    @(negedge clk);
    check("sub_tx_data", bus.o_tx_data, 8'h05);
    pulse_tx_done();

    // Partial frame: watchdog aborts after exactly TIMEOUT cycles in S_OP.
    send_byte(8'h11);
    send_byte(8'h22);
    n = 0;
    while (bus.o_timeout_tick !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_busy", bus.o_busy, 0);
    check("timeout_no_start", bus.o_tx_start, 0);
    check("timeout_keeps_b", bus.o_alu_b, 8'h22);

    // Recovery frame, then a byte arriving while waiting on the transmitter.
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h20);
    @(negedge clk);
    check("recover_tx_data", bus.o_tx_data, 8'h02);
    send_byte(8'h77);
    check("overrun_pulse", bus.o_overrun_tick, 1);
    check("overrun_tx_hold", bus.o_tx_data, 8'h02);
    check("overrun_busy", bus.o_busy, 1);
    @(negedge clk);
    check("overrun_once", bus.o_overrun_tick, 0);
    pulse_tx_done();
    check("overrun_idle", bus.o_busy, 0);

    // Byte arrives on the very cycle the S_B counter reaches TIMEOUT-1.
    send_byte(8'h33);
    repeat (TIMEOUT - 1) @(negedge clk);
    send_byte(8'h44);
    check("race_no_timeout", bus.o_timeout_tick, 0);
    check("race_alu_b", bus.o_alu_b, 8'h44);
    check("race_busy", bus.o_busy, 1);
    send_byte(8'h20);
    @(negedge clk);
    check("race_tx_data", bus.o_tx_data, 8'h77);
    pulse_tx_done();

    // Stray tx_done while idle is ignored.
    pulse_tx_done();
    check("stray_done_idle", bus.o_busy, 0);

    // Asynchronous reset in the middle of a frame.
    send_byte(8'h10);
    send_byte(8'h20);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'h0A);
    send_byte(8'h0B);
    send_byte(8'h20);
    @(negedge clk);
    check("post_reset_tx_data", bus.o_tx_data, 8'h15);
    check("post_reset_start", bus.o_tx_start, 1);
    pulse_tx_done();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Frame controller between the UART (rx/tx/baud-generator top) and the ALU. Collects three received bytes (operand A, operand B, opcode), presents them as registered ALU inputs, captures the ALU result one cycle later, and launches it on the UART transmitter. Includes an inter-byte/transmit watchdog so a partial frame or a stalled transmitter never hangs the link.

## Interface
Parameters:
- DBIT, 8, data byte width (UART and ALU operand width)
- NB_OP, 6, ALU opcode width (low NB_OP bits of third byte)
- TIMEOUT, 1000000, watchdog limit in i_clock cycles (≥2)

Ports:
- i_clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset (0 = reset)
- i_rx_data  in  DBIT  byte from UART receiver
- i_rx_done_tick  in  1  one-cycle pulse, i_rx_data valid
- i_tx_done_tick  in  1  one-cycle pulse, transmitter finished stop bit
- i_alu_result  in  DBIT  combinational ALU output
- o_alu_a  out  DBIT  registered operand A
- o_alu_b  out  DBIT  registered operand B
- o_alu_op  out  NB_OP  registered opcode
- o_tx_data  out  DBIT  registered byte to transmitter
- o_tx_start  out  1  one-cycle start pulse to transmitter
- o_busy  out  1  high in every state except S_A
- o_timeout_tick  out  1  one-cycle pulse, frame aborted by watchdog
- o_overrun_tick  out  1  one-cycle pulse, byte received while not accepting

## Operation
- States: S_A, S_B, S_OP, S_EXEC, S_WAIT_TX. Reset state S_A.
- S_A: on i_rx_done_tick → o_alu_a <= i_rx_data, go S_B. No watchdog.
- S_B: on i_rx_done_tick → o_alu_b <= i_rx_data, go S_OP.
- S_OP: on i_rx_done_tick → o_alu_op <= i_rx_data[NB_OP-1:0] (upper bits discarded), go S_EXEC.
- S_EXEC: unconditional; o_tx_data <= i_alu_result, o_tx_start <= 1, go S_WAIT_TX.
- S_WAIT_TX: on i_tx_done_tick → go S_A.
- Watchdog: counter cleared on every state transition; counts in S_B, S_OP, S_WAIT_TX; when it equals TIMEOUT-1 and no advancing event in that cycle → go S_A, pulse o_timeout_tick. Operand/opcode registers keep last values.
- Simultaneous advancing event and watchdog expiry: event wins, no timeout pulse.
- i_rx_done_tick in S_EXEC or S_WAIT_TX: byte dropped, o_overrun_tick pulses next cycle; state unaffected.
- i_tx_done_tick outside S_WAIT_TX: ignored.
- Reset (any time, mid-frame included): state S_A, counter 0, all outputs 0.

## Timing
- All outputs registered; reset value 0 for every output.
- Byte accepted at edge where i_rx_done_tick=1; register visible the following cycle.
- Opcode latched at edge E0 → o_tx_data valid and o_tx_start=1 from E1 for exactly one cycle (cleared at E2). ALU has one full cycle (E0→E1) to settle.
- o_tx_start and o_tx_data change at the same edge; o_tx_data held until next frame's S_EXEC.
- Minimum frame-to-next-frame-accept: i_tx_done_tick edge → S_A next cycle; rx byte on that same edge is an overrun.
- o_busy = (state != S_A), registered with state.
- Watchdog expiry: exactly TIMEOUT cycles in a waiting state with no event.

## Structure
- Shared package uart_alu_pkg: state encodings, DBIT/NB_OP defaults, counter width ($clog2(TIMEOUT)).
- One sub-module: watchdog_timer (clear, enable, expire output at TIMEOUT-1), instantiated once.
- FSM, operand registers and output registers in uart_alu_ctrl.

## Test plan (TIMEOUT=64)
- Frame 0x05, 0x03, 0x20 with ALU model ADD → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, o_tx_data=0x08, o_tx_start high one cycle, one cycle after opcode edge; i_tx_done_tick → o_busy=0.
- Opcode byte 0xE2 → o_alu_op=0x22.
- Bytes 0x11, 0x22 then silence → o_timeout_tick after exactly 64 cycles in S_OP, o_busy=0, no o_tx_start; next frame 0x01,0x01,0x20 processed correctly.
- rx_done during S_WAIT_TX → o_overrun_tick one pulse, o_tx_data unchanged, state stays S_WAIT_TX.
- i_rx_done_tick on the cycle counter hits 63 in S_B → byte accepted, no timeout pulse.
- Assert i_reset=0 mid-frame (in S_OP) asynchronously → all outputs 0 immediately, state S_A; release and run full frame.
